// File: rtl/ccu_pkg.sv
// Shared definitions for the CCU snoop path:
// CR response bit positions, AC snoop opcodes and the fan-out state encoding.
package ccu_pkg;

    localparam int unsigned CrDataTransfer = 0;
    localparam int unsigned CrError        = 1;
    localparam int unsigned CrPassDirty    = 2;
    localparam int unsigned CrIsShared     = 3;
    localparam int unsigned CrWasUnique    = 4;

    localparam logic [3:0] SnpReadShared   = 4'b0001;
    localparam logic [3:0] SnpReadUnique   = 4'b0111;
    localparam logic [3:0] SnpCleanInvalid = 4'b1001;
    localparam logic [3:0] SnpMakeInvalid  = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SNOOP,
        ST_RESP,
        ST_FWD_CD
    } ccu_state_e;

endpackage

// File: rtl/ccu_snoop_src_sel.sv
// Picks the CD data owner: lowest-index port still holding data.
// Pure combinational priority encoder with a valid flag.
module ccu_snoop_src_sel
    import ccu_pkg::*;
#(
    parameter int unsigned NoMstPorts = 4,
    parameter int unsigned IdxWidth   = 2
) (
    input  logic [NoMstPorts-1:0] i_pend,
    output logic                  o_valid,
    output logic [IdxWidth-1:0]   o_idx
);

    // scan from the top so the lowest set bit wins
    always_comb begin
        o_valid = |i_pend;
        o_idx   = '0;
        for (int i = int'(NoMstPorts) - 1; i >= 0; i--) begin
            if (i_pend[i]) begin
                o_idx = IdxWidth'(i);
            end
        end
    end

endmodule

// File: rtl/ccu_snoop_fanout.sv
// Broadcasts one AC snoop to all masters but the initiator, merges their CR
// responses and forwards the CD beats of one owner while draining the rest.
module ccu_snoop_fanout
    import ccu_pkg::*;
#(
    parameter int unsigned NoMstPorts = 4,
    parameter int unsigned AddrWidth  = 64,
    parameter int unsigned DataWidth  = 64,
    localparam int unsigned IdxWidth  =
        (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            ac_valid_i,
    output logic                            ac_ready_o,
    input  logic [AddrWidth-1:0]            ac_addr_i,
    input  logic [3:0]                      ac_snoop_i,
    input  logic [2:0]                      ac_prot_i,
    input  logic [IdxWidth-1:0]             initiator_i,
    output logic [NoMstPorts-1:0]           mst_ac_valid_o,
    input  logic [NoMstPorts-1:0]           mst_ac_ready_i,
    output logic [AddrWidth-1:0]            mst_ac_addr_o,
    output logic [3:0]                      mst_ac_snoop_o,
    output logic [2:0]                      mst_ac_prot_o,
    input  logic [NoMstPorts-1:0]           mst_cr_valid_i,
    output logic [NoMstPorts-1:0]           mst_cr_ready_o,
    input  logic [NoMstPorts*5-1:0]         mst_cr_resp_i,
    input  logic [NoMstPorts-1:0]           mst_cd_valid_i,
    output logic [NoMstPorts-1:0]           mst_cd_ready_o,
    input  logic [NoMstPorts*DataWidth-1:0] mst_cd_data_i,
    input  logic [NoMstPorts-1:0]           mst_cd_last_i,
    output logic                            cr_valid_o,
    input  logic                            cr_ready_i,
    output logic [4:0]                      cr_resp_o,
    output logic                            cr_data_avail_o,
    output logic                            cd_valid_o,
    input  logic                            cd_ready_i,
    output logic [DataWidth-1:0]            cd_data_o,
    output logic                            cd_last_o
);

    ccu_state_e             r_state;
    logic                   r_ac_ready;
    logic [AddrWidth-1:0]   r_addr;
    logic [3:0]             r_snoop;
    logic [2:0]             r_prot;
    logic [NoMstPorts-1:0]  r_ac_pend;
    logic [NoMstPorts-1:0]  r_cr_pend;
    logic [NoMstPorts-1:0]  r_cd_pend;
    logic [4:0]             r_resp;
    logic [IdxWidth-1:0]    r_src;

    logic [NoMstPorts-1:0]  w_target;
    logic [NoMstPorts-1:0]  w_ac_hs;
    logic [NoMstPorts-1:0]  w_cr_rdy;
    logic [NoMstPorts-1:0]  w_cr_hs;
    logic [NoMstPorts-1:0]  w_dt;
    logic [4:0]             w_resp_or;
    logic [NoMstPorts-1:0]  w_ac_pend_nxt;
    logic [NoMstPorts-1:0]  w_cr_pend_nxt;
    logic [NoMstPorts-1:0]  w_cd_pend_snp;
    logic [NoMstPorts-1:0]  w_cd_rdy;
    logic [NoMstPorts-1:0]  w_cd_done;
    logic [NoMstPorts-1:0]  w_cd_pend_fwd;
    logic [DataWidth-1:0]   w_cd_data [NoMstPorts];
    logic                   w_snoop;
    logic                   w_fwd;
    logic                   w_src_act;
    logic                   w_sel_valid;
    logic [IdxWidth-1:0]    w_sel_idx;

    assign w_snoop = (r_state == ST_SNOOP);
    assign w_fwd   = (r_state == ST_FWD_CD);

    // every port except the requester is a snoop target
    always_comb begin
        w_target = '0;
        for (int i = 0; i < NoMstPorts; i++) begin
            w_target[i] = (IdxWidth'(i) != initiator_i);
        end
    end

    // AC/CR handshakes and the OR-merge of this cycle's responses
    always_comb begin
        w_ac_hs   = '0;
        w_cr_rdy  = '0;
        w_cr_hs   = '0;
        w_dt      = '0;
        w_resp_or = '0;
        for (int i = 0; i < NoMstPorts; i++) begin
            w_ac_hs[i]  = w_snoop & r_ac_pend[i] & mst_ac_ready_i[i];
            w_cr_rdy[i] = w_snoop & r_cr_pend[i] & ~r_ac_pend[i];
            w_cr_hs[i]  = w_cr_rdy[i] & mst_cr_valid_i[i];
            if (w_cr_hs[i]) begin
                w_resp_or = w_resp_or | mst_cr_resp_i[5*i +: 5];
                w_dt[i]   = mst_cr_resp_i[5*i + CrDataTransfer];
            end
        end
    end

    assign w_ac_pend_nxt = r_ac_pend & ~w_ac_hs;
    assign w_cr_pend_nxt = r_cr_pend & ~w_cr_hs;
    assign w_cd_pend_snp = r_cd_pend | w_dt;

    ccu_snoop_src_sel #(
        .NoMstPorts (NoMstPorts),
        .IdxWidth   (IdxWidth)
    ) u_src_sel (
        .i_pend  (w_cd_pend_snp),
        .o_valid (w_sel_valid),
        .o_idx   (w_sel_idx)
    );

    // unpack CD data so the owner can be picked by index
    always_comb begin
        for (int i = 0; i < NoMstPorts; i++) begin
            w_cd_data[i] = mst_cd_data_i[i*DataWidth +: DataWidth];
        end
    end

    // owner follows the FSM's ready; other data holders are drained
    always_comb begin
        w_cd_rdy = '0;
        for (int i = 0; i < NoMstPorts; i++) begin
            if (w_fwd && r_cd_pend[i]) begin
                w_cd_rdy[i] = (IdxWidth'(i) == r_src) ? cd_ready_i : 1'b1;
            end
        end
    end

    assign w_cd_done     = w_cd_rdy & mst_cd_valid_i & mst_cd_last_i;
    assign w_cd_pend_fwd = r_cd_pend & ~w_cd_done;
    assign w_src_act     = w_fwd & r_cd_pend[r_src];

    assign ac_ready_o      = r_ac_ready;
    assign mst_ac_valid_o  = r_ac_pend;
    assign mst_ac_addr_o   = r_addr;
    assign mst_ac_snoop_o  = r_snoop;
    assign mst_ac_prot_o   = r_prot;
    assign mst_cr_ready_o  = w_cr_rdy;
    assign mst_cd_ready_o  = w_cd_rdy;
    assign cr_valid_o      = (r_state == ST_RESP);
    assign cr_resp_o       = cr_valid_o ? r_resp : 5'b0;
    assign cr_data_avail_o = cr_valid_o & (|r_cd_pend);
    assign cd_valid_o      = w_src_act & mst_cd_valid_i[r_src];
    assign cd_data_o       = w_src_act ? w_cd_data[r_src] : '0;
    assign cd_last_o       = w_src_act & mst_cd_last_i[r_src];

    // snoop transaction sequencer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_ac_ready <= 1'b0;
            r_addr     <= '0;
            r_snoop    <= '0;
            r_prot     <= '0;
            r_ac_pend  <= '0;
            r_cr_pend  <= '0;
            r_cd_pend  <= '0;
            r_resp     <= '0;
            r_src      <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (ac_valid_i && r_ac_ready) begin
                        r_addr     <= ac_addr_i;
                        r_snoop    <= ac_snoop_i;
                        r_prot     <= ac_prot_i;
                        r_ac_pend  <= w_target;
                        r_cr_pend  <= w_target;
                        r_cd_pend  <= '0;
                        r_resp     <= '0;
                        r_ac_ready <= 1'b0;
                        r_state    <= (w_target == '0) ? ST_RESP
                                                       : ST_SNOOP;
                    end else begin
                        r_ac_ready <= 1'b1;
                    end
                end
                ST_SNOOP: begin
                    r_ac_pend <= w_ac_pend_nxt;
                    r_cr_pend <= w_cr_pend_nxt;
                    r_cd_pend <= w_cd_pend_snp;
                    r_resp    <= r_resp | w_resp_or;
                    if (w_ac_pend_nxt == '0 && w_cr_pend_nxt == '0) begin
                        r_src   <= w_sel_valid ? w_sel_idx : '0;
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (cr_ready_i) begin
                        if (r_cd_pend != '0) begin
                            r_state <= ST_FWD_CD;
                        end else begin
                            r_state    <= ST_IDLE;
                            r_ac_ready <= 1'b1;
                        end
                    end
                end
                ST_FWD_CD: begin
                    r_cd_pend <= w_cd_pend_fwd;
                    if (w_cd_pend_fwd == '0) begin
                        r_state    <= ST_IDLE;
                        r_ac_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccu_snoop_fanout.sv
// Directed bench for ccu_snoop_fanout: table of snoop scenarios driven by
// a per-port responder, plus hand sequences for reset and single-port use.
module tb_ccu_snoop_fanout;
    import ccu_pkg::*;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int DW = 64;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    initial forever #5 clk_i = ~clk_i;

    logic            ac_valid_i, ac_ready_o;
    logic [AW-1:0]   ac_addr_i;
    logic [3:0]      ac_snoop_i;
    logic [2:0]      ac_prot_i;
    logic [1:0]      initiator_i;
    logic [N-1:0]    mst_ac_valid_o, mst_ac_ready_i;
    logic [AW-1:0]   mst_ac_addr_o;
    logic [3:0]      mst_ac_snoop_o;
    logic [2:0]      mst_ac_prot_o;
    logic [N-1:0]    mst_cr_valid_i, mst_cr_ready_o;
    logic [N*5-1:0]  mst_cr_resp_i;
    logic [N-1:0]    mst_cd_valid_i, mst_cd_ready_o, mst_cd_last_i;
    logic [N*DW-1:0] mst_cd_data_i;
    logic            cr_valid_o, cr_ready_i, cr_data_avail_o;
    logic [4:0]      cr_resp_o;
    logic            cd_valid_o, cd_ready_i, cd_last_o;
    logic [DW-1:0]   cd_data_o;

    logic            ac_valid_1, ac_ready_1, init_1;
    logic            mac_valid_1, mac_ready_1;
    logic [AW-1:0]   maddr_1;
    logic [3:0]      msnoop_1;
    logic [2:0]      mprot_1;
    logic            mcr_valid_1, mcr_ready_1;
    logic [4:0]      mcr_resp_1;
    logic            mcd_valid_1, mcd_ready_1, mcd_last_1;
    logic [DW-1:0]   mcd_data_1;
    logic            cr_valid_1, cr_ready_1, avail_1;
    logic [4:0]      cr_resp_1;
    logic            cd_valid_1, cd_ready_1, cd_last_1;
    logic [DW-1:0]   cd_data_1;

    ccu_snoop_fanout #(.NoMstPorts(N), .AddrWidth(AW), .DataWidth(DW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o),
        .ac_addr_i(ac_addr_i), .ac_snoop_i(ac_snoop_i),
        .ac_prot_i(ac_prot_i), .initiator_i(initiator_i),
        .mst_ac_valid_o(mst_ac_valid_o), .mst_ac_ready_i(mst_ac_ready_i),
        .mst_ac_addr_o(mst_ac_addr_o), .mst_ac_snoop_o(mst_ac_snoop_o),
        .mst_ac_prot_o(mst_ac_prot_o),
        .mst_cr_valid_i(mst_cr_valid_i), .mst_cr_ready_o(mst_cr_ready_o),
        .mst_cr_resp_i(mst_cr_resp_i),
        .mst_cd_valid_i(mst_cd_valid_i), .mst_cd_ready_o(mst_cd_ready_o),
        .mst_cd_data_i(mst_cd_data_i), .mst_cd_last_i(mst_cd_last_i),
        .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i),
        .cr_resp_o(cr_resp_o), .cr_data_avail_o(cr_data_avail_o),
        .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i),
        .cd_data_o(cd_data_o), .cd_last_o(cd_last_o)
    );

    ccu_snoop_fanout #(.NoMstPorts(1), .AddrWidth(AW), .DataWidth(DW)) u_one (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ac_valid_i(ac_valid_1), .ac_ready_o(ac_ready_1),
        .ac_addr_i(64'h40), .ac_snoop_i(SnpReadShared),
        .ac_prot_i(3'b000), .initiator_i(init_1),
        .mst_ac_valid_o(mac_valid_1), .mst_ac_ready_i(mac_ready_1),
        .mst_ac_addr_o(maddr_1), .mst_ac_snoop_o(msnoop_1),
        .mst_ac_prot_o(mprot_1),
        .mst_cr_valid_i(mcr_valid_1), .mst_cr_ready_o(mcr_ready_1),
        .mst_cr_resp_i(mcr_resp_1),
        .mst_cd_valid_i(mcd_valid_1), .mst_cd_ready_o(mcd_ready_1),
        .mst_cd_data_i(mcd_data_1), .mst_cd_last_i(mcd_last_1),
        .cr_valid_o(cr_valid_1), .cr_ready_i(cr_ready_1),
        .cr_resp_o(cr_resp_1), .cr_data_avail_o(avail_1),
        .cd_valid_o(cd_valid_1), .cd_ready_i(cd_ready_1),
        .cd_data_o(cd_data_1), .cd_last_o(cd_last_1)
    );

    typedef struct packed {
        logic [1:0]      init;
        logic [3:0]      op;
        logic [63:0]     addr;
        logic [3:0][4:0] resp;
        logic [3:0][7:0] beats;
        logic [3:0][7:0] ac_dly;
        logic [7:0]      cr_hold;
        logic [3:0]      exp_ac;
        logic [4:0]      exp_resp;
        logic            exp_avail;
        logic [7:0]      exp_cr_t;
        logic [1:0]      src;
        logic [7:0]      nbeats;
        logic [7:0]      exp_cr3;
    } vec_t;

    vec_t vecs [6];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] dat(input int p, input int b);
        return (64'(p) << 8) | 64'(10 + b);
    endfunction

    task automatic idle_inputs();
        ac_valid_i = 0; ac_addr_i = '0; ac_snoop_i = '0; ac_prot_i = '0;
        initiator_i = '0; mst_ac_ready_i = '0; mst_cr_valid_i = '0;
        mst_cr_resp_i = '0; mst_cd_valid_i = '0; mst_cd_data_i = '0;
        mst_cd_last_i = '0; cr_ready_i = 0; cd_ready_i = 0;
        ac_valid_1 = 0; init_1 = 0; mac_ready_1 = 0; mcr_valid_1 = 0;
        mcr_resp_1 = '0; mcd_valid_1 = 0; mcd_data_1 = '0; mcd_last_1 = 0;
        cr_ready_1 = 0; cd_ready_1 = 0;
    endtask

    task automatic run_snoop(input vec_t v, input int vi);
        int t, guard, first_ac, first_cr, cr_t, crv_cnt, nfwd, cr3_t;
        int stall_err, stable_err, data_err, last_err, undrained;
        int ac_wait[4], cr_go[4], beat[4];
        bit ac_done[4], cr_done[4];
        logic [3:0] ac_pat, op_seen;
        logic [63:0] addr_seen;
        logic [4:0] resp_got, resp_hold;
        logic avail_got;
        bit got_cr, done;
        string pf;
        pf = $sformatf("v%0d", vi);
        first_ac = -1; first_cr = -1; cr_t = -1; cr3_t = -1;
        crv_cnt = 0; nfwd = 0; stall_err = 0; stable_err = 0;
        data_err = 0; last_err = 0; undrained = 0;
        ac_pat = '0; op_seen = '0; addr_seen = '0;
        resp_got = '0; resp_hold = '0; avail_got = 0;
        got_cr = 0; done = 0;
        for (int p = 0; p < 4; p++) begin
            ac_wait[p] = 0; cr_go[p] = 0; beat[p] = 0;
            ac_done[p] = 0; cr_done[p] = 0;
        end
        @(negedge clk_i);
        ac_valid_i = 1; ac_addr_i = v.addr; ac_snoop_i = v.op;
        ac_prot_i = 3'b010; initiator_i = v.init;
        guard = 0;
        while (!ac_ready_o && guard < 20) begin
            @(negedge clk_i);
            guard++;
        end
        chk({pf, "_accept"}, ac_ready_o, 1);
        @(negedge clk_i);
        ac_valid_i = 0;
        t = 1;
        while (!done && t < 300) begin
            if (first_ac < 0 && mst_ac_valid_o != 0) begin
                first_ac = t; ac_pat = mst_ac_valid_o;
                addr_seen = mst_ac_addr_o; op_seen = mst_ac_snoop_o;
            end
            if (cr3_t < 0 && mst_cr_ready_o[3]) cr3_t = t;
            if (cr_valid_o) begin
                if (first_cr < 0) begin
                    first_cr = t; resp_hold = cr_resp_o;
                end else if (cr_resp_o !== resp_hold) begin
                    stable_err++;
                end
            end
            if (!got_cr && mst_cd_ready_o != 0) stall_err++;
            for (int p = 0; p < 4; p++) begin
                mst_ac_ready_i[p] = mst_ac_valid_o[p] && ac_wait[p] >= v.ac_dly[p];
                mst_cr_valid_i[p] = ac_done[p] && !cr_done[p] && t >= cr_go[p];
                mst_cr_resp_i[5*p +: 5] = v.resp[p];
                mst_cd_valid_i[p] = cr_done[p] && beat[p] < int'(v.beats[p]);
                mst_cd_data_i[DW*p +: DW] = dat(p, beat[p]);
                mst_cd_last_i[p] = (beat[p] == int'(v.beats[p]) - 1);
            end
            cr_ready_i = cr_valid_o && crv_cnt >= int'(v.cr_hold);
            cd_ready_i = 1;
            #1;
            for (int p = 0; p < 4; p++) begin
                if (mst_ac_valid_o[p] && mst_ac_ready_i[p]) begin
                    ac_done[p] = 1; cr_go[p] = t + 1;
                end else if (mst_ac_valid_o[p]) begin
                    ac_wait[p]++;
                end
                if (mst_cr_valid_i[p] && mst_cr_ready_o[p]) cr_done[p] = 1;
                if (mst_cd_valid_i[p] && mst_cd_ready_o[p]) beat[p]++;
            end
            if (cr_valid_o) crv_cnt++;
            if (cr_valid_o && cr_ready_i) begin
                got_cr = 1; cr_t = t;
                resp_got = cr_resp_o; avail_got = cr_data_avail_o;
            end
            if (cd_valid_o && cd_ready_i) begin
                if (cd_data_o !== dat(int'(v.src), nfwd)) data_err++;
                if (cd_last_o !== (nfwd == int'(v.nbeats) - 1)) last_err++;
                nfwd++;
            end
            @(negedge clk_i);
            t++;
            if (got_cr && ac_ready_o) done = 1;
        end
        idle_inputs();
        for (int p = 0; p < 4; p++) begin
            if (beat[p] != int'(v.beats[p])) undrained++;
        end
        chk({pf, "_done"}, done, 1);
        chk({pf, "_ac_pattern"}, ac_pat, v.exp_ac);
        chk({pf, "_ac_time"}, first_ac, 1);
        chk({pf, "_ac_addr"}, addr_seen, v.addr);
        chk({pf, "_ac_snoop"}, op_seen, v.op);
        chk({pf, "_cr_resp"}, resp_got, v.exp_resp);
        chk({pf, "_data_avail"}, avail_got, v.exp_avail);
        chk({pf, "_cr_valid_time"}, first_cr, v.exp_cr_t);
        chk({pf, "_cr_wait"}, cr_t - first_cr, v.cr_hold);
        chk({pf, "_cr_stable"}, stable_err, 0);
        chk({pf, "_cd_stall"}, stall_err, 0);
        chk({pf, "_fwd_beats"}, nfwd, v.nbeats);
        chk({pf, "_fwd_data"}, data_err, 0);
        chk({pf, "_fwd_last"}, last_err, 0);
        chk({pf, "_undrained"}, undrained, 0);
        if (v.exp_cr3 != 0) chk({pf, "_cr_ready3_time"}, cr3_t, v.exp_cr3);
    endtask

    initial begin
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            vecs[i] = '0;
            vecs[i].init = 2'd1;
            vecs[i].op = SnpReadShared;
            vecs[i].addr = 64'h1000;
            vecs[i].exp_ac = 4'b1101;
            vecs[i].exp_cr_t = 8'd3;
        end
        vecs[1].resp[2] = 5'b00101; vecs[1].beats[2] = 8'd2;
        vecs[1].exp_resp = 5'b00101; vecs[1].exp_avail = 1;
        vecs[1].src = 2'd2; vecs[1].nbeats = 8'd2;
        vecs[2].addr = 64'h2040; vecs[2].op = SnpCleanInvalid;
        vecs[2].resp[0] = 5'b00001; vecs[2].beats[0] = 8'd3;
        vecs[2].resp[3] = 5'b01001; vecs[2].beats[3] = 8'd2;
        vecs[2].exp_resp = 5'b01001; vecs[2].exp_avail = 1;
        vecs[2].src = 2'd0; vecs[2].nbeats = 8'd3;
        vecs[3].addr = 64'h3000; vecs[3].ac_dly[3] = 8'd4;
        vecs[3].cr_hold = 8'd4; vecs[3].resp[0] = 5'b10000;
        vecs[3].exp_resp = 5'b10000; vecs[3].exp_cr_t = 8'd7;
        vecs[3].exp_cr3 = 8'd6;
        vecs[4].init = 2'd0; vecs[4].op = SnpReadUnique;
        vecs[4].addr = 64'hABC0; vecs[4].exp_ac = 4'b1110;
        vecs[4].resp[1] = 5'b00100; vecs[4].resp[3] = 5'b00101;
        vecs[4].beats[3] = 8'd1; vecs[4].exp_resp = 5'b00101;
        vecs[4].exp_avail = 1; vecs[4].src = 2'd3; vecs[4].nbeats = 8'd1;
        vecs[5].init = 2'd3; vecs[5].op = SnpMakeInvalid;
        vecs[5].addr = 64'hFFFF_0000_0000_0080; vecs[5].exp_ac = 4'b0111;
        vecs[5].resp[1] = 5'b00010; vecs[5].exp_resp = 5'b00010;

        #2;
        chk("rst_ac_ready", ac_ready_o, 0);
        chk("rst_mst_ac_valid", mst_ac_valid_o, 0);
        chk("rst_cr_valid", cr_valid_o, 0);
        chk("rst_cd_valid", cd_valid_o, 0);
        chk("rst_ac_addr", mst_ac_addr_o, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1;
        @(negedge clk_i);
        chk("post_rst_ac_ready", ac_ready_o, 1);

        for (int i = 0; i < 6; i++) run_snoop(vecs[i], i);

        @(negedge clk_i);
        ac_valid_i = 1; initiator_i = 2'd1; ac_addr_i = 64'h2000;
        ac_snoop_i = SnpReadUnique; mst_ac_ready_i = 4'hF;
        @(negedge clk_i);
        ac_valid_i = 0;
        chk("r6_ac_valid", mst_ac_valid_o, 4'b1101);
        @(negedge clk_i);
        mst_cr_valid_i = 4'b1101;
        mst_cr_resp_i = '0;
        mst_cr_resp_i[10 +: 5] = 5'b00001;
        @(negedge clk_i);
        mst_cr_valid_i = '0;
        chk("r6_cr_valid", cr_valid_o, 1);
        cr_ready_i = 1;
        @(negedge clk_i);
        cr_ready_i = 0;
        mst_cd_valid_i = 4'b0100;
        mst_cd_data_i[2*DW +: DW] = 64'h77;
        cd_ready_i = 1;
        #1;
        chk("r6_fwd_valid", cd_valid_o, 1);
        chk("r6_fwd_ready", mst_cd_ready_o, 4'b0100);
        #1;
        rst_ni = 0;
        #1;
        chk("r6_ac_ready", ac_ready_o, 0);
        chk("r6_mst_ac_valid", mst_ac_valid_o, 0);
        chk("r6_mst_cr_ready", mst_cr_ready_o, 0);
        chk("r6_mst_cd_ready", mst_cd_ready_o, 0);
        chk("r6_cr_valid_rst", cr_valid_o, 0);
        chk("r6_cd_valid_rst", cd_valid_o, 0);
        chk("r6_cd_data_rst", cd_data_o, 0);
        chk("r6_ac_addr_rst", mst_ac_addr_o, 0);
        idle_inputs();
        @(negedge clk_i);
        rst_ni = 1;
        @(negedge clk_i);
        chk("r6_ready_again", ac_ready_o, 1);
        run_snoop(vecs[1], 6);

        @(negedge clk_i);
        chk("n1_ac_ready", ac_ready_1, 1);
        ac_valid_1 = 1;
        @(negedge clk_i);
        ac_valid_1 = 0;
        chk("n1_no_ac", mac_valid_1, 0);
        chk("n1_cr_valid", cr_valid_1, 1);
        chk("n1_cr_resp", cr_resp_1, 0);
        chk("n1_avail", avail_1, 0);
        cr_ready_1 = 1;
        @(negedge clk_i);
        cr_ready_1 = 0;
        chk("n1_cr_done", cr_valid_1, 0);
        chk("n1_idle", ac_ready_1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
